// File: rtl/sort2_insertion_sorter_if.sv
// rtl/sort2_insertion_sorter_if.sv - sample/result bundle for the top-4 insertion sorter
//
// Groups the incoming sample and the four ranked outputs.
//   a            : new sample, driven by the stream source (master)
//   ra/rb/rc/rd  : ranked retained values, driven by the sorter (slave)
interface sort2_insertion_sorter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rc;
  logic [WIDTH-1:0] rd;

  modport master (
    output a,
    input  ra, rb, rc, rd
  );

  modport slave (
    input  a,
    output ra, rb, rc, rd
  );
endinterface

// File: rtl/sort2_insertion_sorter.sv
// rtl/sort2_insertion_sorter.sv - streaming top-4 insertion sorter
//
// Takes one sample per clock and keeps the four largest values seen since reset,
// ranked ra >= rb >= rc >= rd. Outputs are registered; one cycle of latency.
// Optional macro SORT2_ASCEND_EN: keep the four smallest instead
// (ra <= rb <= rc <= rd) with all registers reset to all-ones.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears the retained set
//   bus    : slave side of sort2_insertion_sorter_if (a in; ra/rb/rc/rd out)
module sort2_insertion_sorter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  sort2_insertion_sorter_if.slave  bus
);

`ifdef SORT2_ASCEND_EN
  // All-ones marks an empty slot: no sample is strictly smaller-than-beaten by it.
  localparam logic [WIDTH-1:0] EMPTY = '1;

  function automatic logic beats(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return x < y;
  endfunction
`else
  // Zero marks an empty slot: a zero sample never beats anything.
  localparam logic [WIDTH-1:0] EMPTY = '0;

  function automatic logic beats(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return x > y;
  endfunction
`endif

  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] rc_q;
  logic [WIDTH-1:0] rd_q;

  // Strict compares: a sample equal to an entry lands below it, so ties
  // never reorder existing entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_q <= EMPTY;
      rb_q <= EMPTY;
      rc_q <= EMPTY;
      rd_q <= EMPTY;
    end else if (beats(bus.a, ra_q)) begin
      ra_q <= bus.a;
      rb_q <= ra_q;
      rc_q <= rb_q;
      rd_q <= rc_q;
    end else if (beats(bus.a, rb_q)) begin
      rb_q <= bus.a;
      rc_q <= rb_q;
      rd_q <= rc_q;
    end else if (beats(bus.a, rc_q)) begin
      rc_q <= bus.a;
      rd_q <= rc_q;
    end else if (beats(bus.a, rd_q)) begin
      rd_q <= bus.a;
    end
  end

  assign bus.ra = ra_q;
  assign bus.rb = rb_q;
  assign bus.rc = rc_q;
  assign bus.rd = rd_q;

endmodule

// File: tb/tb_sort2_insertion_sorter.sv
// tb/tb_sort2_insertion_sorter.sv - self-checking bench for sort2_insertion_sorter
module tb_sort2_insertion_sorter;

  logic clk;
  logic reset;

  sort2_insertion_sorter_if #(.WIDTH(8)) bus ();

  sort2_insertion_sorter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   hist[$];
  int   n_checks = 0;
  int   n_fails  = 0;

`ifdef SORT2_ASCEND_EN
  localparam int EMPTY_VAL = 255;
`else
  localparam int EMPTY_VAL = 0;
`endif

  function automatic void add(input logic r, input logic [7:0] av, input logic [31:0] e);
    vec_t v;
    v.rst = r;
    v.a   = av;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  // Reference: the retained set is simply the best four of every sample since
  // reset, padded with the reset value for empty slots.
  function automatic logic [31:0] model_top4();
    int s[$];
    logic [31:0] r;
    s = hist;
`ifdef SORT2_ASCEND_EN
    s.sort();
`else
    s.rsort();
`endif
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r = r << 8;
      r[7:0] = (i < s.size()) ? 8'(s[i]) : 8'(EMPTY_VAL);
    end
    return r;
  endfunction

  task automatic apply(input logic r, input logic [7:0] av, input logic [31:0] e, input string name);
    logic [31:0] got;
    @(negedge clk);
    reset = r;
    bus.a = av;
    @(posedge clk);
    #1;
    got = {bus.ra, bus.rb, bus.rc, bus.rd};
    n_checks++;
    if (got !== e) begin
      n_fails++;
      $display("FAIL %s: a=%0d got %h expected %h", name, av, got, e);
    end
  endtask

  task automatic step_model(input logic r, input logic [7:0] av, input string name);
    if (r) hist.delete();
    else   hist.push_back(int'(av));
    apply(r, av, model_top4(), name);
  endtask

  initial begin
    reset = 1'b1;
    bus.a = '0;

`ifdef SORT2_ASCEND_EN
    add(1, 8'd0,   32'hffffffff);
    add(1, 8'd0,   32'hffffffff);
    add(0, 8'd5,   32'h05ffffff);
    add(0, 8'd3,   32'h0305ffff);
    add(0, 8'd255, 32'h0305ffff);
    add(0, 8'd4,   32'h030405ff);
    add(1, 8'd1,   32'hffffffff);
    add(0, 8'd7,   32'h07ffffff);
`else
    add(1, 8'd0,   32'h00000000);
    add(1, 8'd0,   32'h00000000);
    add(0, 8'd0,   32'h00000000);
    add(0, 8'd0,   32'h00000000);
    add(0, 8'd0,   32'h00000000);
    add(0, 8'd5,   32'h05000000);
    add(0, 8'd3,   32'h05030000);
    add(0, 8'd9,   32'h09050300);
    add(0, 8'd1,   32'h09050301);
    add(0, 8'd9,   32'h09090503);
    add(0, 8'd2,   32'h09090503);
    add(0, 8'd3,   32'h09090503);
    add(0, 8'd4,   32'h09090504);
    add(1, 8'd200, 32'h00000000);
    add(0, 8'd7,   32'h07000000);
    add(0, 8'd255, 32'hff070000);
    add(0, 8'd255, 32'hffff0700);
    add(0, 8'd255, 32'hffffff07);
    add(0, 8'd255, 32'hffffffff);
    add(0, 8'd0,   32'hffffffff);
    add(0, 8'd128, 32'hffffffff);
    add(0, 8'd254, 32'hffffffff);
`endif

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].rst, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));

    // Ties: repeated equal samples fill every slot, then one more is discarded.
    step_model(1, 8'd0, "tie_reset");
    for (int i = 0; i < 5; i++) step_model(0, 8'd10, $sformatf("tie%0d", i));
    step_model(0, 8'd11, "tie_above");
    step_model(0, 8'd9,  "tie_below");

    // Random stream against the reference.
    step_model(1, 8'd0, "rand_reset");
    for (int i = 0; i < 50; i++)
      step_model(0, 8'($urandom % 256), $sformatf("rand%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
